// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 burst master with local legality check
module axi4_burst_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);
    if (DATA_WIDTH != 32 || ADDR_WIDTH < 12 || MEMORY_DEPTH < 1) begin : g_param_check
        $error("axi4_burst_master: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_CHK, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q, awaddr_q, araddr_q;
    logic [7:0]            len_q, cnt_q, awlen_q, arlen_q;
    logic [2:0]            size_q, awsize_q, arsize_q;
    logic [1:0]            resp_q;
    logic                  err_q, awvalid_q, arvalid_q;

    // Burst end offset within the 4 KiB page; 17 bits hold 4095 + 256*128 without wrap.
    logic [16:0] span_d, end_off_d;
    logic        illegal_d;
    always_comb begin
        span_d    = {8'd0, ({1'b0, len_q} + 9'd1)} << size_q;
        end_off_d = {5'd0, addr_q[11:0]} + span_d;
        illegal_d = (size_q > 3'd2) || (end_off_d > 17'd4096);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    write_q <= cmd_write;
                    addr_q  <= cmd_addr;
                    len_q   <= cmd_len;
                    size_q  <= cmd_size;
                    cnt_q   <= '0;
                    resp_q  <= '0;
                    err_q   <= 1'b0;
                    state_q <= S_CHK;
                end
                S_CHK: begin
                    if (illegal_d) begin
                        resp_q  <= 2'b10;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= write_q ? S_AW : S_AR;
                    end
                end
                // Address registers load with VALID so they only move for legal bursts.
                S_AW: begin
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                        awaddr_q  <= addr_q;
                        awlen_q   <= len_q;
                        awsize_q  <= size_q;
                    end else if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_W;
                    end
                end
                S_W: if (wr_valid && WREADY) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == len_q) state_q <= S_B;
                end
                S_B: if (BVALID) begin
                    resp_q  <= BRESP;
                    state_q <= S_DONE;
                end
                S_AR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= addr_q;
                        arlen_q   <= len_q;
                        arsize_q  <= size_q;
                    end else if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_R;
                    end
                end
                S_R: if (RVALID && rd_ready) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (resp_q == 2'b00) resp_q <= RRESP;
                    if (RLAST) begin
                        if (cnt_q != len_q) err_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == len_q) begin
                        err_q <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic in_w, in_r;
    assign in_w      = (state_q == S_W);
    assign in_r      = (state_q == S_R);
    assign cmd_ready = (state_q == S_IDLE);

    assign AWVALID = awvalid_q;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = awlen_q;
    assign AWSIZE  = awsize_q;
    assign ARVALID = arvalid_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = arlen_q;
    assign ARSIZE  = arsize_q;

    assign WVALID   = in_w & wr_valid;
    assign WDATA    = in_w ? wr_data : '0;
    assign WLAST    = in_w & (cnt_q == len_q);
    assign wr_ready = in_w & WREADY;
    assign BREADY   = (state_q == S_B);

    assign rd_valid = in_r & RVALID;
    assign rd_data  = in_r ? RDATA : '0;
    assign rd_last  = in_r & RLAST;
    assign RREADY   = in_r & rd_ready;

    assign done      = (state_q == S_DONE);
    assign done_err  = done & err_q;
    assign done_resp = resp_q;
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - directed self-checking bench for axi4_burst_master
module tb_axi4_burst_master;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, done_err;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic        WVALID, WLAST, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, RVALID, RLAST, RREADY;

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] rdata_tbl [4] = '{32'hDEADBEEF, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    logic [1:0]  rresp_tbl [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0]  bresp_v = 2'b00;
    bit          rd_toggle = 1'b0;

    int          r_awv, r_wb, r_rb, r_done_at, r_aw_first;
    logic [1:0]  r_resp;
    logic        r_err;

    task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
    endtask

    // Iteration i samples the interval after accept edge N + i.
    task automatic do_burst(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int aw_hold, input int last_beat,
                            input int abort_beat);
        bit aw_done = 1'b0, saw_w = 1'b0, aborted = 1'b0;
        r_awv = 0; r_wb = 0; r_rb = 0; r_done_at = -1; r_aw_first = -1; r_resp = 'x; r_err = 'x;
        send_cmd(wr, addr, len, size);
        for (int i = 0; i < 40 && r_done_at < 0 && !aborted; i++) begin
            if (abort_beat >= 0 && saw_w && r_wb == abort_beat) begin
                ARESET = 1'b1;
                @(posedge ACLK); #1;
                chk("abort_wvalid", {31'd0, WVALID}, 32'd0);
                chk("abort_bready", {31'd0, BREADY}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_awvalid", {31'd0, AWVALID}, 32'd0);
                ARESET  = 1'b0;
                aborted = 1'b1;
            end else begin
                AWREADY  = (r_awv >= aw_hold);
                ARREADY  = (r_awv >= aw_hold);
                WREADY   = 1'b1;
                wr_valid = 1'b1;
                wr_data  = 32'hA000_0000 + r_wb;
                BVALID   = 1'b1;
                BRESP    = bresp_v;
                RVALID   = 1'b1;
                RDATA    = rdata_tbl[r_rb % 4];
                RRESP    = rresp_tbl[r_rb % 4];
                RLAST    = (r_rb == last_beat);
                rd_ready = rd_toggle ? (i % 2 == 1) : 1'b1;
                #1;
                if (AWVALID || ARVALID) begin
                    if (r_aw_first < 0) r_aw_first = i;
                    chk("other_chan_valid", {31'd0, wr ? ARVALID : AWVALID}, 32'd0);
                    chk("ax_addr", {16'd0, wr ? AWADDR : ARADDR}, {16'd0, addr});
                    chk("ax_len", {24'd0, wr ? AWLEN : ARLEN}, {24'd0, len});
                    r_awv++;
                    if (AWREADY) aw_done = 1'b1;
                end
                if (WVALID) begin
                    saw_w = 1'b1;
                    chk("w_after_aw", {31'd0, aw_done}, 32'd1);
                    chk("wr_ready", {31'd0, wr_ready}, 32'd1);
                    chk("wdata", WDATA, 32'hA000_0000 + r_wb);
                    chk("wlast", {31'd0, WLAST}, {31'd0, r_wb == int'(len)});
                    r_wb++;
                end
                if (rd_valid && rd_ready) begin
                    chk("rd_data", rd_data, rdata_tbl[r_rb % 4]);
                    chk("rd_last", {31'd0, rd_last}, {31'd0, r_rb == last_beat});
                    r_rb++;
                end
                if (done) begin
                    r_done_at = i;
                    r_resp    = done_resp;
                    r_err     = done_err;
                    chk("done_vs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                end
                @(posedge ACLK); #1;
            end
        end
        chk("burst_finished", {31'd0, (r_done_at >= 0) || aborted}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BRESP = '0; BVALID = 1'b0; ARREADY = 1'b0;
        RDATA = '0; RRESP = '0; RVALID = 1'b0; RLAST = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_resp", {30'd0, done_resp}, 32'd0);
        chk("rst_awaddr", {16'd0, AWADDR}, 32'd0);
        ARESET = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        do_burst(1'b1, 16'h0010, 8'd3, 3'd2, 0, -1, -1);
        chk("w4_awv", r_awv, 1);
        chk("w4_aw_first", r_aw_first, 2);
        chk("w4_beats", r_wb, 4);
        chk("w4_done_at", r_done_at, 8);
        chk("w4_resp", {30'd0, r_resp}, 32'd0);
        chk("w4_err", {31'd0, r_err}, 32'd0);

        do_burst(1'b0, 16'h0100, 8'd0, 3'd2, 0, 0, -1);
        chk("r1_beats", r_rb, 1);
        chk("r1_done_at", r_done_at, 4);
        chk("r1_resp", {30'd0, r_resp}, 32'd0);
        chk("r1_err", {31'd0, r_err}, 32'd0);

        do_burst(1'b1, 16'h0FF8, 8'd3, 3'd2, 0, -1, -1);
        chk("rej4k_awv", r_awv, 0);
        chk("rej4k_beats", r_wb, 0);
        chk("rej4k_done_at", r_done_at, 1);
        chk("rej4k_resp", {30'd0, r_resp}, 32'd2);
        chk("rej4k_err", {31'd0, r_err}, 32'd1);

        do_burst(1'b1, 16'h0000, 8'd0, 3'd3, 0, -1, -1);
        chk("rejsz_awv", r_awv, 0);
        chk("rejsz_done_at", r_done_at, 1);
        chk("rejsz_resp", {30'd0, r_resp}, 32'd2);
        chk("rejsz_err", {31'd0, r_err}, 32'd1);

        bresp_v = 2'b11;
        do_burst(1'b1, 16'h0FF0, 8'd3, 3'd2, 0, -1, -1);
        chk("edge4k_awv", r_awv, 1);
        chk("edge4k_beats", r_wb, 4);
        chk("edge4k_resp", {30'd0, r_resp}, 32'd3);
        chk("edge4k_err", {31'd0, r_err}, 32'd0);
        bresp_v = 2'b00;

        do_burst(1'b1, 16'h0200, 8'd0, 3'd2, 5, -1, -1);
        chk("hold_awv", r_awv, 6);
        chk("hold_beats", r_wb, 1);
        chk("hold_done_at", r_done_at, 10);

        rresp_tbl = '{2'b00, 2'b10, 2'b11, 2'b00};
        rd_toggle = 1'b1;
        do_burst(1'b0, 16'h0300, 8'd3, 3'd2, 0, 3, -1);
        chk("r4_beats", r_rb, 4);
        chk("r4_resp", {30'd0, r_resp}, 32'd2);
        chk("r4_err", {31'd0, r_err}, 32'd0);

        do_burst(1'b0, 16'h0300, 8'd3, 3'd2, 0, 1, -1);
        chk("rshort_beats", r_rb, 2);
        chk("rshort_resp", {30'd0, r_resp}, 32'd2);
        chk("rshort_err", {31'd0, r_err}, 32'd1);

        rresp_tbl = '{2'b00, 2'b00, 2'b00, 2'b00};
        rd_toggle = 1'b0;
        do_burst(1'b0, 16'h0340, 8'd1, 3'd2, 0, 2, -1);
        chk("rlong_beats", r_rb, 3);
        chk("rlong_resp", {30'd0, r_resp}, 32'd0);
        chk("rlong_err", {31'd0, r_err}, 32'd1);

        do_burst(1'b1, 16'h0400, 8'd3, 3'd2, 0, -1, 1);
        chk("abort_beats", r_wb, 1);
        chk("abort_done_seen", r_done_at, -1);
        chk("post_abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        do_burst(1'b1, 16'h0040, 8'd0, 3'd2, 0, -1, -1);
        chk("post_abort_beats", r_wb, 1);
        chk("post_abort_done_at", r_done_at, 5);
        chk("post_abort_err", {31'd0, r_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

Synthesizable AXI4 master that turns single-word burst commands into AXI4 write or read transactions against the memory-mapped slave. It sits directly upstream of the slave, in place of the bench driver, and fronts it with a simple command / write-data / read-data stream interface. Commands that would be illegal on the bus are rejected locally without any bus activity. Exactly one burst is outstanding at a time.

## Interface
- DATA_WIDTH, 32, AXI data width; the only supported value is 32 (4 bytes per beat).
- ADDR_WIDTH, 16, AXI byte-address width.
- MEMORY_DEPTH, 1024, slave depth in words; informational only, no range check is done here.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 selects a write burst, 0 selects a read burst.
- cmd_addr  in  ADDR_WIDTH  burst start byte address.
- cmd_len  in  8  beats minus 1 (AXI LEN encoding).
- cmd_size  in  3  AXI SIZE encoding.
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  write-data stream.
- rd_valid / rd_ready / rd_data / rd_last  out / in / out / out  1 / 1 / DATA_WIDTH / 1  read-data stream.
- done  out  1  one-cycle pulse at the end of each command.
- done_resp  out  2  final response code, valid while done=1.
- done_err  out  1  1 if the command was rejected or the burst was malformed, valid while done=1.
- AWADDR, AWLEN, AWSIZE, AWVALID  out  ADDR_WIDTH, 8, 3, 1;  AWREADY  in  1.
- WDATA, WVALID, WLAST  out  DATA_WIDTH, 1, 1;  WREADY  in  1.
- BRESP, BVALID  in  2, 1;  BREADY  out  1.
- ARADDR, ARLEN, ARSIZE, ARVALID  out  ADDR_WIDTH, 8, 3, 1;  ARREADY  in  1.
- RDATA, RRESP, RVALID, RLAST  in  DATA_WIDTH, 2, 1, 1;  RREADY  out  1.

## Operation
- FSM states: IDLE, CHK, AW, W, B, AR, R, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid, register the command and clear the beat counter and resp accumulator; go to CHK.
- CHK (one cycle) marks the command illegal if either holds:
  - cmd_size > 2;
  - (addr mod 4096) + (len+1)·2^size > 4096, computed at 13+ bits with no truncation.
- CHK exits:
  - illegal: done_resp=2'b10, done_err=1, go to DONE;
  - legal write: go to AW;
  - legal read: go to AR.
- AW: AWVALID=1 and AWADDR/AWLEN/AWSIZE are driven from registers and stay stable until AWREADY. After the handshake go to W.
- W: write data passes straight through.
  - WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY; all three are gated to 0 outside W.
  - Beat counter increments on each WVALID&&WREADY.
  - WLAST=1 when counter==len.
  - The handshake of the last beat moves the FSM to B.
- B: BREADY=1. On BVALID, latch BRESP into done_resp and go to DONE.
- AR: same as AW, using the AR channel. After the handshake go to R.
- R: read data passes straight through.
  - rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST, RREADY=rd_ready.
  - On each handshake the beat counter increments.
  - done_resp takes the first non-2'b00 RRESP seen in the burst and is kept after that.
  - On the handshake with RLAST=1, go to DONE. done_err=1 if the counter was not equal to len on that beat.
  - If counter==len and RLAST=0, done_err=1; the FSM stays in R until RLAST arrives.
- DONE: done=1 for exactly one cycle, then IDLE.
- No W beat is issued before the AW handshake, and none after the WLAST beat.
- wr_valid in states other than W is ignored and the data is not consumed.

## Timing
- Reset values:
  - all VALID outputs, BREADY, RREADY, wr_ready, rd_valid, done and done_err are 0;
  - WLAST and rd_last are 0;
  - AWADDR/AWLEN/AWSIZE/ARADDR/ARLEN/ARSIZE and done_resp are 0;
  - state is IDLE.
- cmd_ready is 1 on the first cycle after ARESET deasserts.
- Command accepted on edge N: CHK during cycle N+1, AWVALID/ARVALID high from edge N+2.
- A rejected command gives done=1 in cycle N+2; no AXI output toggles.
- Minimum write latency for len=0 with all readies high:
  - AW handshake at edge N+3;
  - W handshake at N+4;
  - B handshake at N+5 at the earliest;
  - done asserted the cycle after the B handshake.
- done is asserted the cycle after the final B or R handshake, and is never asserted in the same cycle as cmd_ready.
- ARESET mid-transaction aborts the burst: all outputs return to reset values at the next edge, and no done pulse is generated.
- The bus is not quiesced on abort; the system resets the slave at the same time.
- Back-to-back commands: the earliest cmd_ready after done is the cycle following done.

## Test plan
- Write: addr 0x0010, len 3, size 2; all readies high; BRESP 2'b00 → one AWVALID pulse with AWLEN=3, four W beats, WLAST only on the 4th, done=1, done_resp=00, done_err=0.
- Read: addr 0x0100, len 0, size 2; slave returns RDATA 0xDEADBEEF, RLAST=1 → rd_data=0xDEADBEEF, rd_last=1, done_resp=00.
- Write: addr 0x0FF8, len 3, size 2 (crosses 0x1000) → no AWVALID ever, done in cycle N+2, done_resp=10, done_err=1. Same result for size=3 at any address.
- Write with AWREADY held low for 5 cycles → AWVALID and AWADDR stable throughout, WVALID stays 0 until after the AW handshake.
- Read len 3 with RRESP 00, 10, 00, 00 and rd_ready toggling → 4 beats forwarded in order, done_resp=10. A variant with RLAST on beat 2 gives done_err=1.
- ARESET pulsed during the 2nd W beat → next edge has WVALID=0, BREADY=0, done=0. After release, cmd_ready=1 and a fresh len 0 write completes normally.
